// File: rtl/croc_block_swap_engine_if.sv
// OBI manager-side bus bundle for the block swap engine.
// master drives the A channel; slave returns gnt and the R channel.
interface croc_block_swap_engine_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;
  logic        a_optional;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rerr;

  modport master (
    output req, addr, we, be, wdata,
    output aid, a_optional,
    input  gnt, rvalid, rdata, rerr
  );

  modport slave (
    input  req, addr, we, be, wdata,
    input  aid, a_optional,
    output gnt, rvalid, rdata, rerr
  );
endinterface

// File: rtl/croc_block_swap_engine.sv
// Swaps two equal-sized SRAM word blocks over OBI, one transaction at a time.
// Ports: clk_i, rst_i, start_i, addr_a_i, addr_b_i, busy_o, done_o, err_o, obi.
module croc_block_swap_engine #(
  parameter int unsigned NumWords = 12,
  parameter logic [31:0] MinAddr  = 32'h1000_0800,
  parameter logic [31:0] SramEnd  = 32'h1000_2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_a_i,
  input  logic [31:0] addr_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  croc_block_swap_engine_if.master obi
);

  localparam int unsigned IdxW =
    (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [31:0] BlkBytes =
    32'(4 * NumWords);
  localparam logic [IdxW-1:0] LastIdx =
    IdxW'(NumWords - 1);

  typedef enum logic [3:0] {
    IDLE, RD_A, WT_A, RD_B, WT_B,
    WR_A, WT_WA, WR_B, WT_WB, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     base_a_q, base_a_d;
  logic [31:0]     base_b_q, base_b_d;
  logic [31:0]     data_a_q, data_a_d;
  logic [31:0]     data_b_q, data_b_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            err_q, err_d;

  logic [31:0] off;
  logic [31:0] diff;
  logic        a_ok, b_ok, cfg_ok;

  // End check written as base <= end - size so it cannot wrap.
  assign a_ok = (addr_a_i[1:0] == 2'b00) &&
                (addr_a_i >= MinAddr) &&
                (addr_a_i <= SramEnd - BlkBytes);
  assign b_ok = (addr_b_i[1:0] == 2'b00) &&
                (addr_b_i >= MinAddr) &&
                (addr_b_i <= SramEnd - BlkBytes);
  assign diff = (addr_a_i >= addr_b_i) ?
                addr_a_i - addr_b_i :
                addr_b_i - addr_a_i;
  assign cfg_ok = a_ok && b_ok && (diff >= BlkBytes);

  assign off = {{(30-IdxW){1'b0}}, idx_q, 2'b00};

  assign obi.aid        = 1'b0;
  assign obi.a_optional = 1'b0;

  assign busy_o = (state_q != IDLE) &&
                  (state_q != DONE);
  assign done_o = (state_q == DONE);
  assign err_o  = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      base_a_q <= '0;
      base_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    idx_d     = idx_q;
    err_d     = err_q;
    obi.req   = 1'b0;
    obi.addr  = '0;
    obi.we    = 1'b0;
    obi.be    = 4'h0;
    obi.wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          base_a_d = addr_a_i;
          base_b_d = addr_b_i;
          idx_d    = '0;
          if (cfg_ok) begin
            err_d   = 1'b0;
            state_d = RD_A;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RD_A: begin
        obi.req  = 1'b1;
        obi.be   = 4'hF;
        obi.addr = base_a_q + off;
        if (obi.gnt) state_d = WT_A;
      end
      RD_B: begin
        obi.req  = 1'b1;
        obi.be   = 4'hF;
        obi.addr = base_b_q + off;
        if (obi.gnt) state_d = WT_B;
      end
      WR_A: begin
        obi.req   = 1'b1;
        obi.be    = 4'hF;
        obi.we    = 1'b1;
        obi.addr  = base_a_q + off;
        obi.wdata = data_b_q;
        if (obi.gnt) state_d = WT_WA;
      end
      WR_B: begin
        obi.req   = 1'b1;
        obi.be    = 4'hF;
        obi.we    = 1'b1;
        obi.addr  = base_b_q + off;
        obi.wdata = data_a_q;
        if (obi.gnt) state_d = WT_WB;
      end
      WT_A, WT_B, WT_WA, WT_WB: begin
        if (obi.rvalid) begin
          if (obi.rerr) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            unique case (state_q)
              WT_A: begin
                data_a_d = obi.rdata;
                state_d  = RD_B;
              end
              WT_B: begin
                data_b_d = obi.rdata;
                state_d  = WR_A;
              end
              WT_WA: state_d = WR_B;
              default: begin
                if (idx_q == LastIdx) begin
                  state_d = DONE;
                end else begin
                  idx_d   = idx_q + IdxW'(1);
                  state_d = RD_A;
                end
              end
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_croc_block_swap_engine.sv
// Randomized bench for croc_block_swap_engine with an OBI SRAM model
// and a transaction-level reference of the expected swap sequence.
module tb_croc_block_swap_engine;
  localparam int NW = 12;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [63:0] MINA = 64'h1000_0800;
  localparam logic [63:0] ENDA = 64'h1000_2000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] addr_a = '0;
  logic [31:0] addr_b = '0;
  logic        busy_o, done_o, err_o;

  croc_block_swap_engine_if obi();

  croc_block_swap_engine dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .addr_a_i (addr_a),
    .addr_b_i (addr_b),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .obi      (obi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [0:2047];
  txn_t exp_q[$];
  int txn_cnt = 0;
  int err_at = -1;
  int maxd = 0;
  int done_cnt = 0;
  int last_cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  function automatic bit in_mem(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h2000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic bit legal(input logic [31:0] a,
                               input logic [31:0] b);
    logic [63:0] ua, ub, d;
    ua = {32'h0, a};
    ub = {32'h0, b};
    d  = (ua > ub) ? ua - ub : ub - ua;
    return (ua % 4 == 0) && (ub % 4 == 0) &&
           ua >= MINA && ub >= MINA &&
           ua + 4 * NW <= ENDA &&
           ub + 4 * NW <= ENDA &&
           d >= 4 * NW;
  endfunction

  // OBI SRAM responder with random grant / response delays.
  initial begin : slave
    bit          pend, was_pend, held, perr;
    int          rcnt, gwait, w;
    logic [31:0] prdata, h_addr, h_wdata;
    logic        h_we;
    txn_t        t;
    pend = 0; held = 0; rcnt = 0; gwait = 0;
    perr = 0; prdata = '0;
    h_addr = '0; h_wdata = '0; h_we = 0;
    obi.gnt = 0; obi.rvalid = 0;
    obi.rdata = '0; obi.rerr = 0;
    forever begin
      @(posedge clk);
      #1;
      obi.gnt = 0;
      obi.rvalid = 0;
      obi.rerr = 0;
      obi.rdata = '0;
      was_pend = pend;
      if (pend) begin
        if (obi.req === 1'b1)
          chk("two_outstanding", 1, 0);
        rcnt--;
        if (rcnt == 0) begin
          obi.rvalid = 1;
          obi.rdata = prdata;
          obi.rerr = perr;
          pend = 0;
        end
      end
      if (rst) begin
        held = 0;
      end else if (obi.req === 1'b1) begin
        if (held) begin
          chk("addr_stable", obi.addr, h_addr);
          chk("we_stable", obi.we, h_we);
          chk("wdata_stable", obi.wdata, h_wdata);
        end else begin
          held = 1;
          h_addr = obi.addr;
          h_we = obi.we;
          h_wdata = obi.wdata;
          gwait = $urandom_range(maxd, 0);
        end
        if (!was_pend && gwait == 0) begin
          obi.gnt = 1;
          held = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_req", obi.addr, 0);
          end else begin
            t = exp_q.pop_front();
            chk("txn_addr", obi.addr, t.addr);
            chk("txn_we", obi.we, t.we);
            if (t.we)
              chk("txn_wdata", obi.wdata, t.wdata);
          end
          prdata = '0;
          if (!in_mem(obi.addr)) begin
            chk("addr_in_sram", obi.addr, BASE);
          end else begin
            w = widx(obi.addr);
            if (obi.we) mem[w] = obi.wdata;
            else prdata = mem[w];
          end
          perr = (txn_cnt == err_at);
          pend = 1;
          rcnt = $urandom_range(1, (maxd < 1) ? 1 : maxd);
          txn_cnt++;
        end else if (gwait > 0) begin
          gwait--;
        end
      end else begin
        if (held) chk("req_dropped", 0, 1);
        held = 0;
      end
    end
  end

  // Per-cycle output checks.
  initial begin : monitor
    bit prev_done;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_done = 0;
      end else begin
        if (obi.req === 1'b1) begin
          chk("be", obi.be, 4'hF);
          chk("aid", obi.aid, 0);
          chk("a_optional", obi.a_optional, 0);
          chk("busy_with_req", busy_o, 1);
        end
        if (done_o === 1'b1) begin
          chk("busy_at_done", busy_o, 0);
          if (prev_done) chk("done_one_cycle", 1, 0);
          done_cnt++;
        end
        prev_done = (done_o === 1'b1);
      end
    end
  end

  task automatic run(input logic [31:0] a,
                     input logic [31:0] b,
                     input int md, input int eat,
                     input int rst_at,
                     input bit repulse,
                     input bit pat);
    logic [31:0] oa [NW];
    logic [31:0] ob [NW];
    logic [31:0] ea, eb, ra, rb;
    bit ok, got, part, rst_done;
    int cyc, k, exp_txn, arm, t0;
    txn_t t;
    maxd = md;
    err_at = eat;
    ok = legal(a, b);
    for (int i = 0; i < NW; i++) begin
      ra = a + 32'(4 * i);
      rb = b + 32'(4 * i);
      if (in_mem(ra))
        mem[widx(ra)] = pat ? 32'hA0 + 32'(i) : $urandom;
      if (in_mem(rb))
        mem[widx(rb)] = pat ? 32'hB0 + 32'(i) : $urandom;
    end
    for (int i = 0; i < NW; i++) begin
      ra = a + 32'(4 * i);
      rb = b + 32'(4 * i);
      oa[i] = in_mem(ra) ? mem[widx(ra)] : '0;
      ob[i] = in_mem(rb) ? mem[widx(rb)] : '0;
    end
    exp_q.delete();
    if (ok) begin
      for (int i = 0; i < NW; i++) begin
        ra = a + 32'(4 * i);
        rb = b + 32'(4 * i);
        t = '{1'b0, ra, 32'h0}; exp_q.push_back(t);
        t = '{1'b0, rb, 32'h0}; exp_q.push_back(t);
        t = '{1'b1, ra, ob[i]}; exp_q.push_back(t);
        t = '{1'b1, rb, oa[i]}; exp_q.push_back(t);
      end
    end
    txn_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #2;
    start = 1; addr_a = a; addr_b = b;
    @(posedge clk); #2;
    start = 0;
    cyc = 1; got = 0; arm = -1; rst_done = 0;
    while (cyc < 3000 && !got && !rst_done) begin
      if (done_o === 1'b1) begin
        got = 1;
      end else if (arm == cyc) begin
        rst = 1;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_req", obi.req, 0);
        chk("rst_addr", obi.addr, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 0;
        rst_done = 1;
      end else begin
        if (ok) begin
          chk("busy_during_op", busy_o, 1);
          chk("err_during_op", err_o, 0);
        end
        if (repulse && cyc == 20) begin
          start = 1;
          addr_a = 32'h1000_1800;
          addr_b = 32'h1000_1900;
        end
        if (repulse && cyc == 21) start = 0;
        if (rst_at >= 0 && arm < 0 &&
            txn_cnt == rst_at + 1)
          arm = cyc + 1;
        @(posedge clk); #2;
        cyc++;
      end
    end
    last_cyc = cyc;
    if (!got && !rst_done)
      chk("done_timeout", cyc, 0);
    if (!rst_done) begin
      @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("err_o",
          err_o, (!ok || eat >= 0) ? 1 : 0);
    end
    t0 = txn_cnt;
    repeat (6) @(posedge clk);
    #2;
    chk("no_req_after", txn_cnt, t0);
    chk("busy_after", busy_o, 0);
    if (!rst_done)
      chk("single_done", done_cnt, 1);
    part = 0;
    if (!ok) begin
      exp_txn = 0; k = 0;
    end else if (rst_done) begin
      exp_txn = rst_at + 1;
      k = rst_at / 4;
      part = (rst_at % 4 == 2);
    end else if (eat >= 0) begin
      exp_txn = eat + 1; k = eat / 4;
    end else begin
      exp_txn = 4 * NW; k = NW;
    end
    chk("txn_count", txn_cnt, exp_txn);
    if (eat < 0 && !rst_done)
      chk("txn_left", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      ra = a + 32'(4 * i);
      rb = b + 32'(4 * i);
      ea = (i < k || (part && i == k)) ? ob[i] : oa[i];
      eb = (i < k) ? oa[i] : ob[i];
      if (in_mem(ra)) chk("mem_a", mem[widx(ra)], ea);
      if (in_mem(rb)) chk("mem_b", mem[widx(rb)], eb);
    end
  endtask

  task automatic rnd_pair(output logic [31:0] a,
                          output logic [31:0] b);
    int wa, wb;
    wa = $urandom_range(2036, 512);
    do wb = $urandom_range(2036, 512);
    while ((wa > wb ? wa - wb : wb - wa) < NW);
    a = BASE + 32'(4 * wa);
    b = BASE + 32'(4 * wb);
  endtask

  initial begin : main
    logic [31:0] ra, rb;
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_err", err_o, 0);
    chk("reset_req", obi.req, 0);
    chk("reset_be", obi.be, 0);
    rst = 0;
    @(posedge clk);

    run(32'h1000_0800, 32'h1000_0900, 0, -1, -1, 0, 1);
    chk("lit_cycles", last_cyc, 97);
    chk("lit_a0", mem[widx(32'h1000_0800)], 32'hB0);
    chk("lit_b11", mem[widx(32'h1000_092C)], 32'hAB);
    chk("lit_txn", txn_cnt, 48);

    for (int n = 0; n < 6; n++) begin
      rnd_pair(ra, rb);
      run(ra, rb, 5, -1, -1, 0, 0);
    end

    run(32'h1000_0800, 32'h1000_1FD0, 3, -1, -1, 0, 0);
    run(32'h1000_1000, 32'h1000_1030, 2, -1, -1, 0, 0);

    run(32'h1000_0804, 32'h1000_0820, 0, -1, -1, 0, 1);
    chk("lit_bad_cyc", last_cyc, 1);
    run(32'h1000_0400, 32'h1000_0900, 0, -1, -1, 0, 1);
    run(32'h1000_0802, 32'h1000_0900, 0, -1, -1, 0, 1);
    run(32'h1000_1FD4, 32'h1000_0900, 0, -1, -1, 0, 1);
    run(32'h1000_1000, 32'h1000_102C, 0, -1, -1, 0, 1);

    run(32'h1000_0800, 32'h1000_0900, 2, 9, -1, 0, 1);
    chk("lit_err_w1a",
        mem[widx(32'h1000_0804)], 32'hB1);
    chk("lit_err_w2a",
        mem[widx(32'h1000_0808)], 32'hA2);

    run(32'h1000_0A00, 32'h1000_0C00, 3, -1, -1, 1, 0);

    run(32'h1000_0800, 32'h1000_0900, 2, -1, 22, 0, 1);
    chk("lit_rst_w5a",
        mem[widx(32'h1000_0814)], 32'hB5);
    chk("lit_rst_w5b",
        mem[widx(32'h1000_0914)], 32'hB5);
    repeat (10) @(posedge clk);
    run(32'h1000_0800, 32'h1000_0900, 0, -1, -1, 0, 1);
    chk("lit_fresh_cyc", last_cyc, 97);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
